ysyx_25060170_ex_mdu: RTL and testbench
=======================================

// Module: ysyx_25060170_ex_mdu
// PURPOSE
//  Iterative RV32M multiply/divide unit in the EX stage, fed directly by the ID/EX pipeline register.
//  Decodes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU from ex_inst and runs a radix-2 shift-add or restoring-divide loop.
//  Asserts mdu_busy, which drives the ID/EX hold input, until the result is accepted downstream.
// PARAMETERS
//  XLEN  32  operand/result width; iteration count = XLEN
// PORTS
//  clk          in   1     clock, rising edge
//  rst          in   1     reset, asynchronous, active-low
//  ex_inst      in   32    instruction held in ID/EX
//  ex_op1       in   XLEN  rs1 value (multiplicand / dividend)
//  ex_op2       in   XLEN  rs2 value (multiplier / divisor)
//  flush        in   1     OR of downstream flushes; kills any in-flight operation
//  ls_stall     in   1     EX/LS not accepting; hold the completed result
//  mdu_busy     out  1     hold ID/EX (combinational from state + decode)
//  mdu_done     out  1     mdu_result valid this cycle
//  mdu_result   out  XLEN  selected product/quotient/remainder
// BEHAVIOUR
//  - is_mdu = (ex_inst[6:0]==7'b0110011) && (ex_inst[31:25]==7'b0000001); op = ex_inst[14:12].
//  - op: 000 MUL low, 001 MULH hi s*s, 010 MULHSU hi s*u, 011 MULHU hi u*u, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
//  - Reset (rst low, async): state=IDLE, cnt=0, acc=0, mdu_result=0, mdu_done=0; mdu_busy forced 0 while rst low.
//  - FSM IDLE/CALC/DONE:
//    IDLE: is_mdu && !flush -> latch |op| magnitudes and result-sign flags, cnt=0, go CALC;
//          special divide cases go straight to DONE with the result loaded; otherwise stay IDLE.
//    CALC: one iteration per cycle; cnt increments; at cnt==XLEN-1 apply sign fix, load mdu_result, go DONE.
//    DONE: mdu_done=1; !ls_stall -> IDLE next edge; ls_stall -> stay, result stable.
//  - mdu_busy = (IDLE && is_mdu) | CALC | (DONE && ls_stall). It drops in the first DONE cycle without a stall, so ID/EX advances on that edge.
//  - Latency: normal op -> mdu_done high XLEN+1 cycles after the instruction appears; special case -> 1 cycle.
//  - Multiply: 2*XLEN accumulator on magnitudes; negate the 64-bit product when sign(op1)^sign(op2) for signed operands.
//  - Divide: restoring on magnitudes; quotient is negated when signs differ; remainder takes the dividend's sign.
//  - Special cases (no iteration):
//    divisor 0 -> quotient all-ones, remainder = dividend.
//    signed 0x80000000 / -1 -> quotient 0x80000000, remainder 0.
//  - flush: highest priority over start/advance; any state -> IDLE next edge; mdu_done low; mdu_result keeps its old value.
//  - Non-MDU instruction: FSM untouched; mdu_busy=0; mdu_done=0.
//  - Same MDU instruction never restarts: ID/EX has already loaded the next instruction when IDLE is re-entered.
// STRUCTURE
//  - Shared defines (define.v): MDU opcode and funct7 constants, funct3 op codes, FSM state encodings (2-bit).
//  - Sub-module ysyx_25060170_mdu_core: accumulator/shift datapath plus iteration counter.
//  - Top level: decode, FSM, sign fix-up, special cases, handshake.
// TESTING
//  1. MUL 7 * 0xFFFFFFFD -> mdu_busy high for 33 cycles; mdu_done in cycle 33; result 0xFFFFFFEB.
//  2. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
//  3. DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
//  4. DIV 5 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; each done in cycle 1.
//  5. flush at cnt==10 in CALC -> IDLE next edge, busy 0, no done pulse.
//     Then DIVU 100 / 7 -> 14 after full latency.
//  6. ls_stall high 3 cycles in DONE -> done/result stable, busy high, exits the edge after ls_stall falls.
//     rst low mid-CALC -> immediate IDLE, all outputs 0.

Source files
------------

// File: rtl/ysyx_25060170_ex_mdu_pkg.sv
// Shared decode constants and FSM state encodings for the EX-stage RV32M multiply/divide unit.
package ysyx_25060170_ex_mdu_pkg;

   localparam logic [6:0] MDU_OPCODE = 7'b0110011;
   localparam logic [6:0] MDU_FUNCT7 = 7'b0000001;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/ysyx_25060170_mdu_core.sv
// Radix-2 iterative datapath: shift-add multiply or restoring divide on unsigned magnitudes.
module ysyx_25060170_mdu_core #(
   parameter int XLEN = 32,
   parameter int CW   = $clog2(XLEN)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic              i_step,
   input  logic              i_is_div,
   input  logic [XLEN-1:0]   i_mag_a,
   input  logic [XLEN-1:0]   i_mag_b,
   output logic [CW-1:0]     o_cnt,
   output logic [2*XLEN-1:0] o_acc_nxt
);

   logic [CW-1:0]     r_cnt;
   logic [2*XLEN-1:0] r_acc;
   logic [XLEN-1:0]   r_opnd;
   logic              r_is_div;

   logic [XLEN-1:0]   w_hi;
   logic [XLEN-1:0]   w_lo;
   logic [XLEN:0]     w_sum;
   logic [XLEN:0]     w_shl;
   logic [XLEN:0]     w_trial;
   logic [2*XLEN-1:0] w_mul_nxt;
   logic [2*XLEN-1:0] w_div_nxt;

   assign w_hi = r_acc[2*XLEN-1:XLEN];
   assign w_lo = r_acc[XLEN-1:0];

   // Multiply: low half holds the multiplier, shifted out LSB-first while the product grows in.
   assign w_sum     = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
   assign w_mul_nxt = {w_sum, w_lo[XLEN-1:1]};

   // Divide: low half holds the dividend, quotient bits shift in as it shifts out.
   assign w_shl     = {w_hi, w_lo[XLEN-1]};
   assign w_trial   = w_shl - {1'b0, r_opnd};
   assign w_div_nxt = w_trial[XLEN] ? {w_shl[XLEN-1:0], w_lo[XLEN-2:0], 1'b0}
                                    : {w_trial[XLEN-1:0], w_lo[XLEN-2:0], 1'b1};

   assign o_acc_nxt = r_is_div ? w_div_nxt : w_mul_nxt;
   assign o_cnt     = r_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
         r_acc <= '0;
      end else if (i_start) begin
         r_cnt <= '0;
         r_acc <= {{XLEN{1'b0}}, (i_is_div ? i_mag_a : i_mag_b)};
      end else if (i_step) begin
         r_cnt <= r_cnt + 1'b1;
         r_acc <= o_acc_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (i_start) begin
         r_opnd   <= i_is_div ? i_mag_b : i_mag_a;
         r_is_div <= i_is_div;
      end
   end

endmodule

// File: rtl/ysyx_25060170_ex_mdu.sv
// EX-stage RV32M unit: decode, IDLE/CALC/DONE control, sign fix-up, divide special cases and ID/EX hold.
module ysyx_25060170_ex_mdu
   import ysyx_25060170_ex_mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     ex_inst,
   input  logic [XLEN-1:0] ex_op1,
   input  logic [XLEN-1:0] ex_op2,
   input  logic            flush,
   input  logic            ls_stall,
   output logic            mdu_busy,
   output logic            mdu_done,
   output logic [XLEN-1:0] mdu_result
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
      return neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
   endfunction

   function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v, input logic neg);
      return neg ? (~v + {{(2*XLEN-1){1'b0}}, 1'b1}) : v;
   endfunction

   logic [1:0]        r_state;
   logic [2:0]        r_op;
   logic              r_neg_q;
   logic              r_neg_r;
   logic [XLEN-1:0]   r_result;

   logic              w_is_mdu;
   logic [2:0]        w_op;
   logic              w_is_div;
   logic              w_a_signed;
   logic              w_b_signed;
   logic              w_a_neg;
   logic              w_b_neg;
   logic [XLEN-1:0]   w_mag_a;
   logic [XLEN-1:0]   w_mag_b;
   logic              w_div0;
   logic              w_ovf;
   logic              w_special;
   logic [XLEN-1:0]   w_spec_res;
   logic              w_start;
   logic              w_step;
   logic              w_last;
   logic [CW-1:0]     w_cnt;
   logic [2*XLEN-1:0] w_acc_nxt;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_quot;
   logic [XLEN-1:0]   w_rem;
   logic [XLEN-1:0]   w_fin_res;
   logic              w_unused_inst;

   assign w_is_mdu      = (ex_inst[6:0] == MDU_OPCODE) && (ex_inst[31:25] == MDU_FUNCT7);
   assign w_op          = ex_inst[14:12];
   assign w_is_div      = w_op[2];
   assign w_unused_inst = ^{ex_inst[24:15], ex_inst[11:7]};

   always_comb begin
      w_a_signed = 1'b1;
      w_b_signed = 1'b1;
      case (w_op)
         F3_MULHSU:                  w_b_signed = 1'b0;
         F3_MULHU, F3_DIVU, F3_REMU: begin
            w_a_signed = 1'b0;
            w_b_signed = 1'b0;
         end
         default: ;
      endcase
   end

   assign w_a_neg = w_a_signed & ex_op1[XLEN-1];
   assign w_b_neg = w_b_signed & ex_op2[XLEN-1];
   assign w_mag_a = cond_neg(ex_op1, w_a_neg);
   assign w_mag_b = cond_neg(ex_op2, w_b_neg);

   // Divide-by-zero and signed overflow bypass the loop entirely.
   assign w_div0    = w_is_div && (ex_op2 == '0);
   assign w_ovf     = w_is_div && !w_op[0] && (ex_op1 == MIN_NEG) && (&ex_op2);
   assign w_special = w_div0 | w_ovf;

   always_comb begin
      w_spec_res = '0;
      case (w_op)
         F3_DIV, F3_DIVU: w_spec_res = w_div0 ? {XLEN{1'b1}} : MIN_NEG;
         F3_REM, F3_REMU: w_spec_res = w_div0 ? ex_op1 : '0;
         default:         w_spec_res = '0;
      endcase
   end

   assign w_start = (r_state == ST_IDLE) && w_is_mdu && !flush && !w_special;
   assign w_step  = (r_state == ST_CALC) && !flush;
   assign w_last  = (w_cnt == CW'(XLEN-1));

   ysyx_25060170_mdu_core #(
      .XLEN (XLEN),
      .CW   (CW)
   ) u_core (
      .clk       (clk),
      .rst       (rst),
      .i_start   (w_start),
      .i_step    (w_step),
      .i_is_div  (w_is_div),
      .i_mag_a   (w_mag_a),
      .i_mag_b   (w_mag_b),
      .o_cnt     (w_cnt),
      .o_acc_nxt (w_acc_nxt)
   );

   // The final iteration's value is consumed directly so DONE follows the last CALC cycle.
   assign w_prod = cond_neg2(w_acc_nxt, r_neg_q);
   assign w_quot = cond_neg(w_acc_nxt[XLEN-1:0], r_neg_q);
   assign w_rem  = cond_neg(w_acc_nxt[2*XLEN-1:XLEN], r_neg_r);

   always_comb begin
      w_fin_res = w_rem;
      case (r_op)
         F3_MUL:                       w_fin_res = w_prod[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: w_fin_res = w_prod[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:              w_fin_res = w_quot;
         default:                      w_fin_res = w_rem;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= ST_IDLE;
         r_result <= '0;
      end else if (flush) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_is_mdu) begin
                  if (w_special) begin
                     r_state  <= ST_DONE;
                     r_result <= w_spec_res;
                  end else begin
                     r_state <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               if (w_last) begin
                  r_state  <= ST_DONE;
                  r_result <= w_fin_res;
               end
            end
            ST_DONE: begin
               if (!ls_stall) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_start) begin
         r_op    <= w_op;
         r_neg_q <= w_a_neg ^ w_b_neg;
         r_neg_r <= w_a_neg;
      end
   end

   assign mdu_done   = (r_state == ST_DONE) && !flush;
   assign mdu_busy   = rst && (((r_state == ST_IDLE) && w_is_mdu) || (r_state == ST_CALC) ||
                               ((r_state == ST_DONE) && ls_stall));
   assign mdu_result = r_result;

endmodule

// File: tb/tb_ysyx_25060170_ex_mdu.sv
// Randomized bench for the EX-stage MDU, checked against a plain-arithmetic RV32M reference model.
module tb_ysyx_25060170_ex_mdu;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ex_inst;
   logic [31:0] ex_op1;
   logic [31:0] ex_op2;
   logic        flush;
   logic        ls_stall;
   logic        mdu_busy;
   logic        mdu_done;
   logic [31:0] mdu_result;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] ADD = 32'h0020_81B3;

   always #5 clk = ~clk;

   ysyx_25060170_ex_mdu #(.XLEN(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .ex_inst    (ex_inst),
      .ex_op1     (ex_op1),
      .ex_op2     (ex_op2),
      .flush      (flush),
      .ls_stall   (ls_stall),
      .mdu_busy   (mdu_busy),
      .mdu_done   (mdu_done),
      .mdu_result (mdu_result)
   );

   function automatic logic [31:0] mk_inst(input logic [2:0] op);
      return {7'b0000001, 5'd2, 5'd1, op, 5'd3, 7'b0110011};
   endfunction

   function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p;
      logic [31:0]     r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      r  = '0;
      case (op)
         3'd0: begin p = sa * sb; r = p[31:0]; end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
         3'd3: begin p = ua * ub; r = p[63:32]; end
         3'd4: begin if (b == 0) r = 32'hFFFF_FFFF; else begin p = sa / sb; r = p[31:0]; end end
         3'd5: begin if (b == 0) r = 32'hFFFF_FFFF; else r = a / b; end
         3'd6: begin if (b == 0) r = a; else begin p = sa % sb; r = p[31:0]; end end
         default: begin if (b == 0) r = a; else r = a % b; end
      endcase
      return r;
   endfunction

   function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op[2] && (b == 0)) return 1;
      if (op[2] && !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
      return 33;
   endfunction

   // Issue one instruction and wait for mdu_done; chained_in/chained_out model back-to-back ID/EX loads.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit chained_in, input bit chained_out,
                        output logic [31:0] res, output int lat, output int busy_n);
      if (!chained_in) begin
         @(posedge clk);
         #1;
      end
      ex_inst = mk_inst(op);
      ex_op1  = a;
      ex_op2  = b;
      lat     = -1;
      busy_n  = 0;
      res     = '0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (mdu_busy) busy_n++;
         if (mdu_done) begin
            lat = k;
            res = mdu_result;
            break;
         end
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      if (!chained_out) ex_inst = NOP;
   endtask

   task automatic test_reset;
      rst      = 1'b0;
      flush    = 1'b0;
      ls_stall = 1'b0;
      ex_inst  = mk_inst(3'd0);
      ex_op1   = 32'd3;
      ex_op2   = 32'd4;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (mdu_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b exp 0", mdu_busy); end
      n_checks++; if (mdu_done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b exp 0", mdu_done); end
      n_checks++; if (mdu_result !== 32'd0) begin n_errors++; $display("FAIL reset_result got %h exp 0", mdu_result); end
      ex_inst = NOP;
      rst     = 1'b1;
      @(negedge clk);
      n_checks++; if (mdu_busy !== 1'b0 || mdu_done !== 1'b0) begin n_errors++; $display("FAIL nop_idle got busy=%b done=%b exp 0 0", mdu_busy, mdu_done); end
      ex_inst = ADD;
      @(negedge clk);
      n_checks++; if (mdu_busy !== 1'b0 || mdu_done !== 1'b0) begin n_errors++; $display("FAIL add_not_mdu got busy=%b done=%b exp 0 0", mdu_busy, mdu_done); end
      ex_inst = NOP;
   endtask

   task automatic test_mul_latency;
      logic [31:0] r;
      int lat, bn;
      do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0, r, lat, bn);
      n_checks++; if (r !== 32'hFFFF_FFEB) begin n_errors++; $display("FAIL mul_result got %h exp ffffffeb", r); end
      n_checks++; if (lat !== 33) begin n_errors++; $display("FAIL mul_latency got %0d exp 33", lat); end
      n_checks++; if (bn !== 33) begin n_errors++; $display("FAIL mul_busy_cycles got %0d exp 33", bn); end
      @(negedge clk);
      n_checks++; if (mdu_done !== 1'b0 || mdu_busy !== 1'b0) begin n_errors++; $display("FAIL mul_after got done=%b busy=%b exp 0 0", mdu_done, mdu_busy); end
   endtask

   task automatic test_mul_high;
      logic [31:0] r;
      int lat, bn;
      do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, r, lat, bn);
      n_checks++; if (r !== 32'hFFFF_FFFE || lat !== 33) begin n_errors++; $display("FAIL mulhu got %h lat %0d exp fffffffe lat 33", r, lat); end
      do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, r, lat, bn);
      n_checks++; if (r !== 32'h0000_0000 || lat !== 33) begin n_errors++; $display("FAIL mulh got %h lat %0d exp 00000000 lat 33", r, lat); end
      do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, r, lat, bn);
      n_checks++; if (r !== 32'hFFFF_FFFF || lat !== 33) begin n_errors++; $display("FAIL mulhsu got %h lat %0d exp ffffffff lat 33", r, lat); end
   endtask

   task automatic test_div;
      logic [31:0] r;
      int lat, bn;
      do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, r, lat, bn);
      n_checks++; if (r !== 32'hFFFF_FFFD || lat !== 33) begin n_errors++; $display("FAIL div_neg got %h lat %0d exp fffffffd lat 33", r, lat); end
      do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, r, lat, bn);
      n_checks++; if (r !== 32'hFFFF_FFFF || lat !== 33) begin n_errors++; $display("FAIL rem_neg got %h lat %0d exp ffffffff lat 33", r, lat); end
      do_op(3'd5, 32'd100, 32'd7, 1'b0, 1'b0, r, lat, bn);
      n_checks++; if (r !== 32'd14 || lat !== 33) begin n_errors++; $display("FAIL divu got %h lat %0d exp 0000000e lat 33", r, lat); end
      do_op(3'd7, 32'd100, 32'd7, 1'b0, 1'b0, r, lat, bn);
      n_checks++; if (r !== 32'd2 || lat !== 33) begin n_errors++; $display("FAIL remu got %h lat %0d exp 00000002 lat 33", r, lat); end
   endtask

   task automatic test_special;
      logic [31:0] r;
      int lat, bn;
      do_op(3'd4, 32'd5, 32'd0, 1'b0, 1'b0, r, lat, bn);
      n_checks++; if (r !== 32'hFFFF_FFFF || lat !== 1 || bn !== 1) begin n_errors++; $display("FAIL div_by_zero got %h lat %0d busy %0d exp ffffffff lat 1 busy 1", r, lat, bn); end
      do_op(3'd6, 32'd5, 32'd0, 1'b0, 1'b0, r, lat, bn);
      n_checks++; if (r !== 32'd5 || lat !== 1) begin n_errors++; $display("FAIL rem_by_zero got %h lat %0d exp 00000005 lat 1", r, lat); end
      do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, r, lat, bn);
      n_checks++; if (r !== 32'h8000_0000 || lat !== 1) begin n_errors++; $display("FAIL div_ovf got %h lat %0d exp 80000000 lat 1", r, lat); end
      do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, r, lat, bn);
      n_checks++; if (r !== 32'd0 || lat !== 1) begin n_errors++; $display("FAIL rem_ovf got %h lat %0d exp 00000000 lat 1", r, lat); end
   endtask

   task automatic test_flush;
      logic [31:0] r;
      int lat, bn, pulses;
      @(posedge clk);
      #1;
      ex_inst = mk_inst(3'd5);
      ex_op1  = 32'd100;
      ex_op2  = 32'd7;
      repeat (11) @(posedge clk);
      #1;
      flush = 1'b1;
      @(negedge clk);
      n_checks++; if (mdu_done !== 1'b0) begin n_errors++; $display("FAIL flush_cycle_done got %b exp 0", mdu_done); end
      @(posedge clk);
      #1;
      flush   = 1'b0;
      ex_inst = NOP;
      @(negedge clk);
      n_checks++; if (mdu_busy !== 1'b0 || mdu_done !== 1'b0) begin n_errors++; $display("FAIL flush_idle got busy=%b done=%b exp 0 0", mdu_busy, mdu_done); end
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (mdu_done) pulses++;
      end
      n_checks++; if (pulses !== 0) begin n_errors++; $display("FAIL flush_no_done got %0d pulses exp 0", pulses); end
      do_op(3'd5, 32'd100, 32'd7, 1'b0, 1'b0, r, lat, bn);
      n_checks++; if (r !== 32'd14 || lat !== 33) begin n_errors++; $display("FAIL divu_after_flush got %h lat %0d exp 0000000e lat 33", r, lat); end
   endtask

   task automatic test_stall;
      logic [31:0] held;
      int lat;
      @(posedge clk);
      #1;
      ls_stall = 1'b1;
      ex_inst  = mk_inst(3'd3);
      ex_op1   = 32'hFFFF_FFFF;
      ex_op2   = 32'hFFFF_FFFF;
      lat      = -1;
      held     = '0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (mdu_done) begin
            lat  = k;
            held = mdu_result;
            break;
         end
      end
      n_checks++; if (lat !== 33 || held !== 32'hFFFF_FFFE) begin n_errors++; $display("FAIL stall_first got %h lat %0d exp fffffffe lat 33", held, lat); end
      n_checks++; if (mdu_busy !== 1'b1) begin n_errors++; $display("FAIL stall_busy got %b exp 1", mdu_busy); end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_checks++;
         if (mdu_done !== 1'b1 || mdu_busy !== 1'b1 || mdu_result !== 32'hFFFF_FFFE) begin
            n_errors++;
            $display("FAIL stall_hold got done=%b busy=%b res=%h exp 1 1 fffffffe", mdu_done, mdu_busy, mdu_result);
         end
      end
      @(posedge clk);
      #1;
      ls_stall = 1'b0;
      @(negedge clk);
      n_checks++; if (mdu_done !== 1'b1 || mdu_busy !== 1'b0 || mdu_result !== 32'hFFFF_FFFE) begin n_errors++; $display("FAIL stall_release got done=%b busy=%b res=%h exp 1 0 fffffffe", mdu_done, mdu_busy, mdu_result); end
      @(posedge clk);
      #1;
      ex_inst = NOP;
      @(negedge clk);
      n_checks++; if (mdu_done !== 1'b0) begin n_errors++; $display("FAIL stall_exit got done=%b exp 0", mdu_done); end
   endtask

   task automatic test_reset_mid;
      @(posedge clk);
      #1;
      ex_inst = mk_inst(3'd0);
      ex_op1  = $urandom;
      ex_op2  = $urandom;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      n_checks++; if (mdu_busy !== 1'b0 || mdu_done !== 1'b0 || mdu_result !== 32'd0) begin n_errors++; $display("FAIL reset_mid got busy=%b done=%b res=%h exp 0 0 0", mdu_busy, mdu_done, mdu_result); end
      @(negedge clk);
      ex_inst = NOP;
      rst     = 1'b1;
      @(negedge clk);
      n_checks++; if (mdu_busy !== 1'b0 || mdu_done !== 1'b0) begin n_errors++; $display("FAIL reset_mid_after got busy=%b done=%b exp 0 0", mdu_busy, mdu_done); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] r;
      int lat, bn;
      do_op(3'd4, 32'hFFFF_FF00, 32'd7, 1'b0, 1'b1, r, lat, bn);
      n_checks++; if (r !== ref_mdu(3'd4, 32'hFFFF_FF00, 32'd7) || lat !== 33) begin n_errors++; $display("FAIL b2b_first got %h lat %0d exp %h lat 33", r, lat, ref_mdu(3'd4, 32'hFFFF_FF00, 32'd7)); end
      do_op(3'd1, 32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0, r, lat, bn);
      n_checks++; if (r !== ref_mdu(3'd1, 32'h1234_5678, 32'h8765_4321) || lat !== 33) begin n_errors++; $display("FAIL b2b_second got %h lat %0d exp %h lat 33", r, lat, ref_mdu(3'd1, 32'h1234_5678, 32'h8765_4321)); end
   endtask

   task automatic test_random;
      logic [31:0] r, a, b, exp_r;
      logic [2:0]  op;
      int lat, bn, exp_l, sel;
      for (int i = 0; i < 40; i++) begin
         op  = 3'($urandom_range(0, 7));
         sel = $urandom_range(0, 5);
         a   = $urandom;
         b   = $urandom;
         if (sel == 0) b = 32'd0;
         else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         else if (sel == 2) b = 32'($urandom_range(1, 15));
         exp_r = ref_mdu(op, a, b);
         exp_l = ref_lat(op, a, b);
         do_op(op, a, b, 1'b0, 1'b0, r, lat, bn);
         n_checks++;
         if (r !== exp_r || lat !== exp_l) begin
            n_errors++;
            $display("FAIL random op=%0d a=%h b=%h got %h lat %0d exp %h lat %0d", op, a, b, r, lat, exp_r, exp_l);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_mul_latency();
      test_mul_high();
      test_div();
      test_special();
      test_flush();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
